// File: rtl/debug_display.sv
// Seven-segment debug display: snapshots one of NUM_CH debug channels and shows a
// NUM_DIGITS-nibble page of it, with manual/auto channel cycling, paging and freeze.
module displayconverter (
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);
   // active-low segments, bit order gfedcba
   always_comb begin
      o_seg = 7'b1000000;
      case (i_nib)
         4'h0: o_seg = 7'b1000000;
         4'h1: o_seg = 7'b1111001;
         4'h2: o_seg = 7'b0100100;
         4'h3: o_seg = 7'b0110000;
         4'h4: o_seg = 7'b0011001;
         4'h5: o_seg = 7'b0010010;
         4'h6: o_seg = 7'b0000010;
         4'h7: o_seg = 7'b1111000;
         4'h8: o_seg = 7'b0000000;
         4'h9: o_seg = 7'b0010000;
         4'hA: o_seg = 7'b0001000;
         4'hB: o_seg = 7'b0000011;
         4'hC: o_seg = 7'b1000110;
         4'hD: o_seg = 7'b0100001;
         4'hE: o_seg = 7'b0000110;
         4'hF: o_seg = 7'b0001110;
         default: o_seg = 7'b1000000;
      endcase
   end
endmodule

module debug_display #(
   parameter  int NUM_DIGITS  = 6,
   parameter  int NUM_CH      = 4,
   parameter  int DATA_W      = 32,
   parameter  int CYCLE_TICKS = 50_000_000,
   localparam int PAGES       = (DATA_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS),
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PG_W        = (PAGES > 1) ? $clog2(PAGES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     debug,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic                     auto_mode,
   input  logic                     step,
   input  logic                     page_step,
   input  logic                     freeze,
   output logic [NUM_DIGITS*7-1:0]  segments,
   output logic [CH_W-1:0]          ch_sel,
   output logic [PG_W-1:0]          page
);
   localparam int WIN_W = NUM_DIGITS*4;
   localparam int PAD_W = PAGES*WIN_W;

   logic              r_step_s, r_step_p, r_pstep_s, r_pstep_p, r_auto_q;
   logic [31:0]       r_tick;
   logic [CH_W-1:0]   r_ch;
   logic [PG_W-1:0]   r_page;
   logic [DATA_W-1:0] r_snap;
   logic [NUM_DIGITS*7-1:0] r_seg;

   logic              w_step_edge, w_pstep_edge, w_adv;
   logic [31:0]       w_tick_nxt;
   logic [CH_W-1:0]   w_ch_nxt;
   logic [PG_W-1:0]   w_page_nxt;
   logic [DATA_W-1:0] w_sel;
   logic [PAD_W-1:0]  w_pad;
   logic [WIN_W-1:0]  w_win;
   logic [NUM_DIGITS*7-1:0] w_seg;

   assign w_step_edge  = r_step_s & ~r_step_p;
   assign w_pstep_edge = r_pstep_s & ~r_pstep_p;
   assign w_sel        = DATA_W'(ch_data >> (32'(r_ch) * DATA_W));

   always_comb begin
      w_adv      = 1'b0;
      w_tick_nxt = '0;
      if (auto_mode) begin
         // counter restarts on entry to auto mode so the first period is full length
         if (auto_mode == r_auto_q) begin
            if (r_tick == 32'(CYCLE_TICKS-1)) w_adv = 1'b1;
            else                              w_tick_nxt = r_tick + 32'd1;
         end
      end else begin
         w_adv = w_step_edge;
      end
      w_ch_nxt   = r_ch;
      w_page_nxt = r_page;
      if (w_adv) begin
         w_ch_nxt   = (r_ch == CH_W'(NUM_CH-1)) ? '0 : r_ch + 1'b1;
         w_page_nxt = '0;
      end else if (w_pstep_edge) begin
         w_page_nxt = (r_page == PG_W'(PAGES-1)) ? '0 : r_page + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_step_s  <= 1'b0;
         r_step_p  <= 1'b0;
         r_pstep_s <= 1'b0;
         r_pstep_p <= 1'b0;
         r_auto_q  <= 1'b0;
         r_tick    <= '0;
         r_ch      <= '0;
         r_page    <= '0;
         r_snap    <= '0;
      end else begin
         r_step_s  <= step;
         r_step_p  <= r_step_s;
         r_pstep_s <= page_step;
         r_pstep_p <= r_pstep_s;
         r_auto_q  <= auto_mode;
         if (!freeze) begin
            r_snap <= w_sel;
            r_tick <= w_tick_nxt;
            r_ch   <= w_ch_nxt;
            r_page <= w_page_nxt;
         end
      end
   end

   // nibbles past DATA_W fall into the zero padding
   assign w_pad = PAD_W'(r_snap);
   assign w_win = WIN_W'(w_pad >> (32'(r_page) * WIN_W));

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
      displayconverter u_conv (
         .i_nib (debug ? w_win[d*4 +: 4] : 4'h0),
         .o_seg (w_seg[d*7 +: 7])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_seg <= {NUM_DIGITS{7'b1000000}};
      else      r_seg <= w_seg;
   end

   assign segments = r_seg;
   assign ch_sel   = r_ch;
   assign page     = r_page;
endmodule

// File: tb/tb_debug_display.sv
// Randomised + directed bench for debug_display against a cycle-level behavioural model.
module tb_debug_display;
   localparam int ND = 6, NCH = 4, DW = 32, CT = 8;
   localparam int PAGES = 2;
   localparam logic [41:0] SEG_ZERO = {6{7'b1000000}};

   logic          clk = 0, rst = 0, debug = 0, auto_mode = 0, step = 0, page_step = 0, freeze = 0;
   logic [127:0]  ch_data = '0;
   logic [41:0]   segments;
   logic [1:0]    ch_sel;
   logic [0:0]    page;

   debug_display #(.NUM_DIGITS(ND), .NUM_CH(NCH), .DATA_W(DW), .CYCLE_TICKS(CT)) dut (
      .clk(clk), .rst(rst), .debug(debug), .ch_data(ch_data), .auto_mode(auto_mode),
      .step(step), .page_step(page_step), .freeze(freeze),
      .segments(segments), .ch_sel(ch_sel), .page(page));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] conv(input logic [3:0] n);
      logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[n];
   endfunction

   // six hex digits (digit0 in bits [3:0]) to the expected segment word
   function automatic logic [41:0] segs_of(input logic [23:0] hex);
      logic [41:0] r;
      for (int d = 0; d < ND; d++) r[d*7 +: 7] = conv(hex[d*4 +: 4]);
      return r;
   endfunction

   function automatic logic [41:0] show(input logic [31:0] snap, input int pg, input logic dbg);
      logic [23:0] h;
      logic [63:0] w;
      w = 64'(snap) >> (pg * ND * 4);
      h = dbg ? w[23:0] : 24'h0;
      return segs_of(h);
   endfunction

   // behavioural model: inputs history, channel/page/tick as plain integers
   int          m_ch = 0, m_page = 0, m_tick = 0;
   logic [31:0] m_snap = '0, m_nsnap;
   logic [41:0] m_seg = SEG_ZERO;
   logic        m_s1 = 0, m_s2 = 0, m_p1 = 0, m_p2 = 0, m_auto_prev = 0;
   logic        m_se, m_pe, m_adv;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ch = 0; m_page = 0; m_tick = 0; m_snap = '0; m_seg = SEG_ZERO;
         m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0; m_auto_prev = 0;
      end else begin
         m_se  = m_s1 && !m_s2;
         m_pe  = m_p1 && !m_p2;
         m_adv = 0;
         m_seg = show(m_snap, m_page, debug);
         if (!freeze) begin
            m_nsnap = ch_data[m_ch*DW +: DW];
            if (!auto_mode) begin
               m_tick = 0;
               m_adv  = m_se;
            end else if (!m_auto_prev) m_tick = 0;
            else if (m_tick == CT-1) begin m_tick = 0; m_adv = 1; end
            else m_tick++;
            if (m_adv) begin m_ch = (m_ch + 1) % NCH; m_page = 0; end
            else if (m_pe) m_page = (m_page + 1) % PAGES;
            m_snap = m_nsnap;
         end
         m_s2 = m_s1; m_s1 = step; m_p2 = m_p1; m_p1 = page_step; m_auto_prev = auto_mode;
      end
   end

   always @(negedge clk) begin
      chk("ch_sel", 64'(ch_sel), 64'(m_ch));
      chk("page", 64'(page), 64'(m_page));
      chk("segments", 64'(segments), 64'(m_seg));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_step();
      step = 1; cyc(1); step = 0; cyc(3);
   endtask

   task automatic pulse_page();
      page_step = 1; cyc(1); page_step = 0; cyc(3);
   endtask

   int exp_ch[5] = '{1, 2, 3, 0, 1};
   int fch, cnt;
   logic [41:0] fseg;
   logic [1:0]  prev;

   initial begin
      ch_data[31:0]   = 32'h00ABCDEF;
      ch_data[63:32]  = 32'h00A1B2C3;
      ch_data[95:64]  = 32'h00546372;
      ch_data[127:96] = 32'h00908172;
      cyc(2);
      rst = 1;
      cyc(3);
      chk("blank_debug0", 64'(segments), 64'(SEG_ZERO));
      debug = 1;
      cyc(2);
      chk("debug_on_FEDCBA", 64'(segments), 64'(segs_of(24'hABCDEF)));

      for (int i = 0; i < 5; i++) begin
         pulse_step();
         chk("manual_ch", 64'(ch_sel), 64'(exp_ch[i]));
      end
      chk("manual_ch1_segs", 64'(segments), 64'(segs_of(24'hA1B2C3)));
      for (int i = 0; i < 3; i++) pulse_step();
      chk("back_to_ch0", 64'(ch_sel), 64'd0);

      ch_data[31:0] = 32'h12345678;
      cyc(3);
      chk("page0_segs", 64'(segments), 64'(segs_of(24'h345678)));
      pulse_page();
      chk("page1", 64'(page), 64'd1);
      chk("page1_segs", 64'(segments), 64'(segs_of(24'h000012)));
      pulse_page();
      chk("page_wrap", 64'(page), 64'd0);

      // page_step edge lands on the same cycle as the auto advance
      pulse_page();
      auto_mode = 1;
      cnt = 0;
      do begin cyc(1); cnt++; end while (m_tick != CT-2 && cnt < 30);
      chk("tick_reach_timeout", 64'(cnt < 30), 64'd1);
      chk("page_before_collide", 64'(page), 64'd1);
      page_step = 1; cyc(1); page_step = 0; cyc(1);
      chk("collide_ch", 64'(ch_sel), 64'd1);
      chk("collide_page", 64'(page), 64'd0);
      for (int k = 0; k < 2; k++) begin
         prev = ch_sel; cnt = 0;
         do begin cyc(1); cnt++; end while (ch_sel == prev && cnt < 30);
         chk("auto_period", 64'(cnt), 64'(CT));
      end

      auto_mode = 0;
      cyc(3);
      fch = m_ch; fseg = m_seg;
      freeze = 1;
      ch_data[fch*DW +: DW] = 32'hFFFFFFFF;
      step = 1;
      cyc(4);
      chk("freeze_ch", 64'(ch_sel), 64'(fch));
      chk("freeze_segs", 64'(segments), 64'(fseg));
      freeze = 0;
      cyc(2);
      chk("unfreeze_segs", 64'(segments), 64'(segs_of(24'hFFFFFF)));
      cyc(3);
      chk("no_spurious_step", 64'(ch_sel), 64'(fch));
      step = 0;
      cyc(2);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) ch_data = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 2) == 0) step = ~step;
         if ($urandom_range(0, 2) == 0) page_step = ~page_step;
         if ($urandom_range(0, 39) == 0) freeze = ~freeze;
         if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
         if ($urandom_range(0, 49) == 0) debug = ~debug;
         cyc(1);
      end

      freeze = 0; auto_mode = 0; debug = 1; step = 0; page_step = 0;
      cyc(3);
      for (int i = 0; i < 4 && m_ch != 2; i++) pulse_step();
      for (int i = 0; i < 2 && m_page != 1; i++) pulse_page();
      chk("pre_reset_ch", 64'(ch_sel), 64'd2);
      chk("pre_reset_page", 64'(page), 64'd1);
      #2 rst = 0;
      #1;
      chk("async_rst_ch", 64'(ch_sel), 64'd0);
      chk("async_rst_page", 64'(page), 64'd0);
      chk("async_rst_segs", 64'(segments), 64'(SEG_ZERO));
      cyc(2);
      rst = 1;
      cyc(20);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
